// File: rtl/idex_hazard_register_if.sv
// ID/EX bundle: ID-stage inputs, registered EX-stage outputs and hazard controls.
// The master side drives ID_*/Flush/ExtStall; the slave side is the ID/EX register.
interface idex_hazard_register_if #(
  parameter int CTRL_W = 12
);
  logic [31:0]       ID_Instruction;
  logic [31:0]       ID_PCPlus4;
  logic [31:0]       ID_ReadData1;
  logic [31:0]       ID_ReadData2;
  logic [31:0]       ID_SignExtImm;
  logic [CTRL_W-1:0] ID_Control;
  logic              ID_Valid;
  logic              ID_MemRead;
  logic              ID_UsesRs;
  logic              ID_UsesRt;
  logic              Flush;
  logic              ExtStall;

  logic [31:0]       EX_Instruction;
  logic [31:0]       EX_PCPlus4;
  logic [31:0]       EX_ReadData1;
  logic [31:0]       EX_ReadData2;
  logic [31:0]       EX_SignExtImm;
  logic [CTRL_W-1:0] EX_Control;
  logic              EX_Valid;
  logic              EX_MemRead;
  logic              PCWrite;
  logic              IFIDWrite;
  logic              LoadUseStall;
  logic [31:0]       StallCount;

  modport master (
    output ID_Instruction, ID_PCPlus4, ID_ReadData1, ID_ReadData2, ID_SignExtImm,
           ID_Control, ID_Valid, ID_MemRead, ID_UsesRs, ID_UsesRt, Flush, ExtStall,
    input  EX_Instruction, EX_PCPlus4, EX_ReadData1, EX_ReadData2, EX_SignExtImm,
           EX_Control, EX_Valid, EX_MemRead, PCWrite, IFIDWrite, LoadUseStall, StallCount
  );

  modport slave (
    input  ID_Instruction, ID_PCPlus4, ID_ReadData1, ID_ReadData2, ID_SignExtImm,
           ID_Control, ID_Valid, ID_MemRead, ID_UsesRs, ID_UsesRt, Flush, ExtStall,
    output EX_Instruction, EX_PCPlus4, EX_ReadData1, EX_ReadData2, EX_SignExtImm,
           EX_Control, EX_Valid, EX_MemRead, PCWrite, IFIDWrite, LoadUseStall, StallCount
  );
endinterface

// File: rtl/idex_hazard_register.sv
// ID/EX pipeline register with load-use hazard detection and multi-cycle bubble insertion.
// Optional bubble-cycle counter on StallCount is enabled by defining IDEX_STALL_COUNTER_EN.
module idex_hazard_register #(
  parameter int CTRL_W       = 12,
  parameter int STALL_CYCLES = 1
) (
  input logic                   Clock,
  input logic                   Reset,
  idex_hazard_register_if.slave bus
);
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [3:0] HOLD_CNT = 4'(STALL_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       rd1_q, rd1_d;
  logic [31:0]       rd2_q, rd2_d;
  logic [31:0]       imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic              memread_q, memread_d;

  logic              hazard;
  logic [4:0]        rt_ex;
  logic              pc_write, ifid_write, load_use_stall;

  assign rt_ex  = instr_q[20:16];
  assign hazard = valid_q && memread_q && bus.ID_Valid && (rt_ex != 5'd0) &&
                  ((bus.ID_UsesRs && (rt_ex == bus.ID_Instruction[25:21])) ||
                   (bus.ID_UsesRt && (rt_ex == bus.ID_Instruction[20:16])));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    instr_d        = instr_q;
    pc_d           = pc_q;
    rd1_d          = rd1_q;
    rd2_d          = rd2_q;
    imm_d          = imm_q;
    ctrl_d         = ctrl_q;
    valid_d        = valid_q;
    memread_d      = memread_q;
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    load_use_stall = 1'b0;

    if (bus.Flush) begin
      {instr_d, pc_d, rd1_d, rd2_d, imm_d} = '0;
      ctrl_d    = '0;
      valid_d   = 1'b0;
      memread_d = 1'b0;
      state_d   = RUN;
      cnt_d     = '0;
    end else if (bus.ExtStall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (state_q == HOLD || hazard) begin
      // A bubble zeroes the whole entry so the forwarder sees rs=rt=0.
      {instr_d, pc_d, rd1_d, rd2_d, imm_d} = '0;
      ctrl_d         = '0;
      valid_d        = 1'b0;
      memread_d      = 1'b0;
      pc_write       = 1'b0;
      ifid_write     = 1'b0;
      load_use_stall = 1'b1;
      if (state_q == HOLD) begin
        if (cnt_q == 4'd1) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end else if (STALL_CYCLES > 1) begin
        state_d = HOLD;
        cnt_d   = HOLD_CNT;
      end
    end else begin
      instr_d   = bus.ID_Instruction;
      pc_d      = bus.ID_PCPlus4;
      rd1_d     = bus.ID_ReadData1;
      rd2_d     = bus.ID_ReadData2;
      imm_d     = bus.ID_SignExtImm;
      ctrl_d    = bus.ID_Control;
      valid_d   = bus.ID_Valid;
      memread_d = bus.ID_MemRead;
    end
  end

`ifdef IDEX_STALL_COUNTER_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (load_use_stall && !bus.ExtStall && (stall_count_q != '1))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign bus.StallCount = stall_count_q;
`else
  assign bus.StallCount = '0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      instr_q   <= '0;
      pc_q      <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      memread_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      memread_q <= memread_d;
    end
  end

  assign bus.EX_Instruction = instr_q;
  assign bus.EX_PCPlus4     = pc_q;
  assign bus.EX_ReadData1   = rd1_q;
  assign bus.EX_ReadData2   = rd2_q;
  assign bus.EX_SignExtImm  = imm_q;
  assign bus.EX_Control     = ctrl_q;
  assign bus.EX_Valid       = valid_q;
  assign bus.EX_MemRead     = memread_q;
  assign bus.PCWrite        = pc_write;
  assign bus.IFIDWrite      = ifid_write;
  assign bus.LoadUseStall   = load_use_stall;
endmodule

// File: tb/tb_idex_hazard_register.sv
// Directed bench: vector table on a STALL_CYCLES=1 instance, hand sequences on a
// STALL_CYCLES=3 instance for hold, flush-in-hold and freeze-in-hold cases.
module tb_idex_hazard_register;
  localparam int CW = 12;
`ifdef IDEX_STALL_COUNTER_EN
  localparam logic [31:0] CNT_ON = 32'd1;
`else
  localparam logic [31:0] CNT_ON = 32'd0;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 Clock = ~Clock;

  idex_hazard_register_if #(.CTRL_W(CW)) if1 ();
  idex_hazard_register_if #(.CTRL_W(CW)) if3 ();

  idex_hazard_register #(.CTRL_W(CW), .STALL_CYCLES(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .bus(if1.slave));
  idex_hazard_register #(.CTRL_W(CW), .STALL_CYCLES(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .bus(if3.slave));

  typedef enum int {K_LOAD, K_BUBBLE, K_HOLD} kind_t;
  typedef struct {
    logic [31:0] instr;
    logic valid, mr, rs, rt, flush, ext;
    logic pcw, ifid, lus;
    kind_t kind;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set3(input logic [31:0] instr, input logic valid, input logic mr,
                      input logic rs, input logic rt, input logic flush, input logic ext);
    if3.ID_Instruction = instr;
    if3.ID_PCPlus4     = 32'h0000_1004;
    if3.ID_ReadData1   = 32'h1111_1111;
    if3.ID_ReadData2   = 32'h2222_2222;
    if3.ID_SignExtImm  = 32'h3333_3333;
    if3.ID_Control     = 12'hABC;
    if3.ID_Valid       = valid;
    if3.ID_MemRead     = mr;
    if3.ID_UsesRs      = rs;
    if3.ID_UsesRt      = rt;
    if3.Flush          = flush;
    if3.ExtStall       = ext;
  endtask

  logic [31:0]   e_instr, e_pc, e_rd1, e_rd2, e_imm;
  logic [CW-1:0] e_ctrl;
  logic          e_valid, e_mr;
  logic [31:0]   sc0;

  initial begin
    //          instr         v     mr    rs    rt    fl    ext   pcw   ifid  lus
    vecs[0]  = '{32'h8D280000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[1]  = '{32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, K_BUBBLE};
    vecs[2]  = '{32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[3]  = '{32'h8C200000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[4]  = '{32'h000B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[5]  = '{32'h8D280000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[6]  = '{32'hAD280000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[7]  = '{32'h8D280000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[8]  = '{32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, K_HOLD};
    vecs[9]  = '{32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, K_HOLD};
    vecs[10] = '{32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, K_BUBBLE};
    vecs[11] = '{32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[12] = '{32'h8D280000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[13] = '{32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, K_BUBBLE};
    vecs[14] = '{32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, K_BUBBLE};
    vecs[15] = '{32'h010B5020, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[16] = '{32'h8D280000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[17] = '{32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[18] = '{32'h8D280000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[19] = '{32'h01285020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, K_BUBBLE};
    vecs[20] = '{32'h01285020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[21] = '{32'h8D280000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};
    vecs[22] = '{32'h010B5020, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_LOAD};

    if1.ID_Instruction = '0; if1.ID_PCPlus4 = '0; if1.ID_ReadData1 = '0;
    if1.ID_ReadData2 = '0; if1.ID_SignExtImm = '0; if1.ID_Control = '0;
    if1.ID_Valid = 1'b0; if1.ID_MemRead = 1'b0; if1.ID_UsesRs = 1'b0;
    if1.ID_UsesRt = 1'b0; if1.Flush = 1'b0; if1.ExtStall = 1'b0;
    set3(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge Clock);
    chk("rst_instr1", if1.EX_Instruction, 32'h0);
    chk("rst_valid1", {31'b0, if1.EX_Valid}, 32'h0);
    chk("rst_ctrl1", {20'b0, if1.EX_Control}, 32'h0);
    chk("rst_pcw1", {31'b0, if1.PCWrite}, 32'h1);
    chk("rst_cnt1", if1.StallCount, 32'h0);
    chk("rst_instr3", if3.EX_Instruction, 32'h0);
    Reset = 1'b0;

    e_instr = '0; e_pc = '0; e_rd1 = '0; e_rd2 = '0; e_imm = '0;
    e_ctrl = '0; e_valid = 1'b0; e_mr = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge Clock);
      if1.ID_Instruction = vecs[i].instr;
      if1.ID_PCPlus4     = 32'h0040_0000 + 32'(i * 4);
      if1.ID_ReadData1   = 32'h1000_0000 + 32'(i);
      if1.ID_ReadData2   = 32'h2000_0000 + 32'(i);
      if1.ID_SignExtImm  = 32'h3000_0000 + 32'(i);
      if1.ID_Control     = CW'(i + 1);
      if1.ID_Valid       = vecs[i].valid;
      if1.ID_MemRead     = vecs[i].mr;
      if1.ID_UsesRs      = vecs[i].rs;
      if1.ID_UsesRt      = vecs[i].rt;
      if1.Flush          = vecs[i].flush;
      if1.ExtStall       = vecs[i].ext;
      #1;
      chk($sformatf("v%0d_pcw", i), {31'b0, if1.PCWrite}, {31'b0, vecs[i].pcw});
      chk($sformatf("v%0d_ifid", i), {31'b0, if1.IFIDWrite}, {31'b0, vecs[i].ifid});
      chk($sformatf("v%0d_lus", i), {31'b0, if1.LoadUseStall}, {31'b0, vecs[i].lus});
      case (vecs[i].kind)
        K_LOAD: begin
          e_instr = if1.ID_Instruction; e_pc = if1.ID_PCPlus4;
          e_rd1 = if1.ID_ReadData1; e_rd2 = if1.ID_ReadData2; e_imm = if1.ID_SignExtImm;
          e_ctrl = if1.ID_Control; e_valid = vecs[i].valid; e_mr = vecs[i].mr;
        end
        K_BUBBLE: begin
          e_instr = '0; e_pc = '0; e_rd1 = '0; e_rd2 = '0; e_imm = '0;
          e_ctrl = '0; e_valid = 1'b0; e_mr = 1'b0;
        end
        default: ;
      endcase
      @(posedge Clock); #1;
      chk($sformatf("v%0d_instr", i), if1.EX_Instruction, e_instr);
      chk($sformatf("v%0d_pc", i), if1.EX_PCPlus4, e_pc);
      chk($sformatf("v%0d_rd1", i), if1.EX_ReadData1, e_rd1);
      chk($sformatf("v%0d_rd2", i), if1.EX_ReadData2, e_rd2);
      chk($sformatf("v%0d_imm", i), if1.EX_SignExtImm, e_imm);
      chk($sformatf("v%0d_ctrl", i), {20'b0, if1.EX_Control}, {20'b0, e_ctrl});
      chk($sformatf("v%0d_valid", i), {31'b0, if1.EX_Valid}, {31'b0, e_valid});
      chk($sformatf("v%0d_mr", i), {31'b0, if1.EX_MemRead}, {31'b0, e_mr});
    end
    if1.Flush = 1'b0; if1.ExtStall = 1'b0;
    chk("tbl_stallcount", if1.StallCount, 32'd3 * CNT_ON);

    // STALL_CYCLES=3: three bubbles, then the dependent add
    sc0 = if3.StallCount;
    @(negedge Clock); set3(32'h8D280000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge Clock); set3(32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("s3_b%0d_lus", k), {31'b0, if3.LoadUseStall}, 32'h1);
      chk($sformatf("s3_b%0d_pcw", k), {31'b0, if3.PCWrite}, 32'h0);
      @(posedge Clock); #1;
      chk($sformatf("s3_b%0d_instr", k), if3.EX_Instruction, 32'h0);
      chk($sformatf("s3_b%0d_valid", k), {31'b0, if3.EX_Valid}, 32'h0);
      @(negedge Clock);
    end
    #1;
    chk("s3_rel_lus", {31'b0, if3.LoadUseStall}, 32'h0);
    chk("s3_rel_pcw", {31'b0, if3.PCWrite}, 32'h1);
    @(posedge Clock); #1;
    chk("s3_add_instr", if3.EX_Instruction, 32'h010B5020);
    chk("s3_add_valid", {31'b0, if3.EX_Valid}, 32'h1);
    chk("s3_stallcount", if3.StallCount - sc0, 32'd3 * CNT_ON);

    // Flush in the second bubble cycle returns the FSM to RUN
    sc0 = if3.StallCount;
    @(negedge Clock); set3(32'h8D280000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge Clock); set3(32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("fl_b0_lus", {31'b0, if3.LoadUseStall}, 32'h1);
    @(negedge Clock); set3(32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    #1 chk("fl_pcw", {31'b0, if3.PCWrite}, 32'h1);
    @(posedge Clock); #1;
    chk("fl_valid", {31'b0, if3.EX_Valid}, 32'h0);
    chk("fl_instr", if3.EX_Instruction, 32'h0);
    @(negedge Clock); set3(32'h012A4020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("fl_run_lus", {31'b0, if3.LoadUseStall}, 32'h0);
    @(posedge Clock); #1;
    chk("fl_next_instr", if3.EX_Instruction, 32'h012A4020);
    chk("fl_stallcount", if3.StallCount - sc0, 32'd1 * CNT_ON);

    // ExtStall mid-HOLD freezes CNT: two bubbles remain after release
    sc0 = if3.StallCount;
    @(negedge Clock); set3(32'h8D280000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge Clock); set3(32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge Clock); set3(32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("xs_f%0d_lus", k), {31'b0, if3.LoadUseStall}, 32'h0);
      chk($sformatf("xs_f%0d_ifid", k), {31'b0, if3.IFIDWrite}, 32'h0);
      @(posedge Clock); #1;
      chk($sformatf("xs_f%0d_cnt", k), if3.StallCount - sc0, 32'd1 * CNT_ON);
      @(negedge Clock);
    end
    set3(32'h010B5020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1 chk($sformatf("xs_b%0d_lus", k), {31'b0, if3.LoadUseStall}, 32'h1);
      @(posedge Clock); #1;
      chk($sformatf("xs_b%0d_instr", k), if3.EX_Instruction, 32'h0);
      @(negedge Clock);
    end
    #1 chk("xs_rel_lus", {31'b0, if3.LoadUseStall}, 32'h0);
    @(posedge Clock); #1;
    chk("xs_add_instr", if3.EX_Instruction, 32'h010B5020);
    chk("xs_stallcount", if3.StallCount - sc0, 32'd3 * CNT_ON);

    // Asynchronous reset mid-operation
    @(negedge Clock);
    if1.ID_Instruction = 32'h012A4020; if1.ID_Valid = 1'b1; if1.ID_MemRead = 1'b0;
    @(posedge Clock); #1;
    chk("ar_pre_instr", if1.EX_Instruction, 32'h012A4020);
    #2 Reset = 1'b1;
    #1;
    chk("ar_instr", if1.EX_Instruction, 32'h0);
    chk("ar_valid", {31'b0, if1.EX_Valid}, 32'h0);
    chk("ar_pc", if1.EX_PCPlus4, 32'h0);
    chk("ar_rd1", if1.EX_ReadData1, 32'h0);
    chk("ar_pcw", {31'b0, if1.PCWrite}, 32'h1);
    chk("ar_cnt", if1.StallCount, 32'h0);
    @(negedge Clock); Reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/idex_hazard_register.md
Name: idex_hazard_register

Overview:
- ID/EX pipeline register plus load-use hazard unit for the 5-stage MIPS pipeline.
- Sits directly upstream of the forwarding unit and drives its EX_Instruction input; also drives the EX-stage datapath.
- Detects load-use hazards that forwarding cannot cover.
- On a hazard it freezes PC and IF/ID, and inserts bubbles into ID/EX for STALL_CYCLES cycles.

Parameters:
CTRL_W, 12, width of the packed EX/MEM/WB control bundle.
STALL_CYCLES, 1, number of bubbles per load-use hazard (1..15; use >1 for slow data memory).

Ports:
Clock  input  1  pipeline clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
ID_Instruction  input  32  decoded instruction in ID.
ID_PCPlus4  input  32  PC+4 of the ID instruction.
ID_ReadData1  input  32  register file port A (rs).
ID_ReadData2  input  32  register file port B (rt).
ID_SignExtImm  input  32  sign-extended immediate.
ID_Control  input  CTRL_W  control bundle from the controller.
ID_Valid  input  1  ID holds a real instruction.
ID_MemRead  input  1  ID instruction is a load.
ID_UsesRs  input  1  ID instruction reads rs.
ID_UsesRt  input  1  ID instruction reads rt as a source.
Flush  input  1  branch/jump taken; kill the ID/EX contents.
ExtStall  input  1  global pipeline freeze (multi-cycle unit).
EX_Instruction  output  32  registered instruction.
EX_PCPlus4  output  32  registered PC+4.
EX_ReadData1  output  32  registered rs data.
EX_ReadData2  output  32  registered rt data.
EX_SignExtImm  output  32  registered immediate.
EX_Control  output  CTRL_W  registered control bundle.
EX_Valid  output  1  EX holds a real instruction.
EX_MemRead  output  1  EX instruction is a load.
PCWrite  output  1  0 = hold the PC.
IFIDWrite  output  1  0 = hold the IF/ID register.
LoadUseStall  output  1  a hazard bubble is being inserted this cycle.
StallCount  output  32  count of bubble cycles (see Optional Feature).

Behaviour:
- Reset (asynchronous): all EX_* outputs become 0, the FSM goes to RUN, the counter goes to 0, and StallCount goes to 0. An all-zero instruction is sll $0 (a NOP), so the forwarder sees no dependence.
- Hazard condition H (combinational):
  - EX_Valid & EX_MemRead & ID_Valid & (EX_Instruction[20:16] != 0), and
  - either (ID_UsesRs & rt_EX == ID_Instruction[25:21]) or (ID_UsesRt & rt_EX == ID_Instruction[20:16]).
- FSM states: RUN and HOLD, plus a 4-bit counter CNT.
- Per-edge priority: Reset > Flush > ExtStall > bubble > load.
- Flush (any state):
  - ID/EX loads a bubble: all fields 0, Valid 0, MemRead 0.
  - FSM goes to RUN, CNT goes to 0.
  - Flush overrides ExtStall.
- ExtStall (no Flush):
  - ID/EX, FSM and CNT all hold.
  - PCWrite=0, IFIDWrite=0, LoadUseStall=0.
- RUN with H:
  - Load a bubble; PCWrite=0, IFIDWrite=0, LoadUseStall=1.
  - If STALL_CYCLES>1: go to HOLD with CNT=STALL_CYCLES-1. Otherwise stay in RUN.
- HOLD:
  - Load a bubble; PCWrite=0, IFIDWrite=0, LoadUseStall=1.
  - Decrement CNT. When CNT==1 on this edge, go to RUN (CNT goes to 0).
  - H is ignored in HOLD: the load has already left EX.
- RUN without H: load all ID_* fields; PCWrite=1, IFIDWrite=1, LoadUseStall=0.
- PCWrite, IFIDWrite and LoadUseStall are combinational from state, H, Flush and ExtStall.
- Latency:
  - A non-stalled ID instruction appears on EX_* one cycle later.
  - A hazarded instruction appears STALL_CYCLES+1 cycles after it is first detected.
- A bubble is a full zeroing of the register, never only the control bundle. The forwarder keys on the instruction field, so it must see rs=rt=0.
- Destination $0 never triggers a stall.
- Back-to-back hazards re-trigger normally once the FSM is back in RUN.

Optional Feature:
- Macro: IDEX_STALL_COUNTER_EN.
- Defined:
  - StallCount is a 32-bit register, cleared by Reset.
  - It increments on every edge where LoadUseStall=1 and ExtStall=0.
  - It saturates at 32'hFFFFFFFF.
- Undefined: StallCount is tied to 32'h0 and no counter flops are synthesised.

Test Plan:
- Reset mid-operation: assert Reset asynchronously while EX_Instruction=32'h012A4020 -> all EX_* outputs read 0 before the next edge; PCWrite=1.
- Load-use, STALL_CYCLES=1:
  - Stimulus: EX holds lw $8,0($9) (32'h8D280000); ID holds add $10,$8,$11 (32'h010B5020) with UsesRs=1.
  - Response: one cycle with LoadUseStall=1, PCWrite=0, IFIDWrite=0, then a bubble in EX. On the next edge EX_Instruction=32'h010B5020.
- STALL_CYCLES=3, same pair -> exactly 3 consecutive bubble cycles, then the add enters EX. StallCount increases by 3 with IDEX_STALL_COUNTER_EN defined.
- No false stall:
  - lw $0,... followed by a use of $0 -> no stall.
  - lw $8 followed by sw with UsesRt=0 and rt=8 -> no stall.
- Flush during HOLD (STALL_CYCLES=3, Flush asserted in the 2nd bubble cycle) -> FSM returns to RUN, EX_Valid=0, and the next ID instruction loads on the following edge.
- ExtStall=1 for 2 cycles with EX_Instruction=32'h8D280000 -> EX_* outputs unchanged, CNT unchanged, StallCount unchanged; the FSM resumes when ExtStall deasserts.
